// File: rtl/fas_fft_sched.sv
// Frame scheduler: fills a ping-pong sample buffer from the FIR stream and walks
// each full bank through the radix-2 FFT stages via a start/done handshake.
module fas_fft_sched #(
    parameter int FRAME_LEN  = 16,
    parameter int NUM_STAGES = 4,
    parameter int NUM_FRAMES = 64,
    localparam int AW = $clog2(FRAME_LEN),
    localparam int SW = $clog2(NUM_STAGES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fir_valid,
    input  logic          stage_done,
    output logic          buf_wr_en,
    output logic          buf_wr_bank,
    output logic [AW-1:0] buf_wr_addr,
    output logic          fft_start,
    output logic          fft_bank,
    output logic [SW-1:0] fft_stage,
    output logic          fft_valid,
    output logic [6:0]    frame_cnt,
    output logic          done,
    output logic          overrun,
    output logic [2:0]    fsm_state
);

    // Handshake: fir_valid is a one-cycle offer with no back-pressure; buf_wr_en
    // reports whether the offer was taken. fft_start and stage_done are one-cycle
    // pulses, and only a stage_done seen in WAIT advances the stage sequence.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state;
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       bypass;
    logic       accept;
    logic       wr_last;
    logic       clr_full;

    assign fft_start = (state == S_START);
    assign fft_valid = (state == S_OUT);
    assign done      = (state == S_DONE);
    assign fsm_state = state;

    // The bank being released this cycle may already take its first new sample.
    assign bypass    = (state == S_OUT) && (fft_bank == buf_wr_bank) && (buf_wr_addr == '0);
    assign accept    = fir_valid && !done && (!full[buf_wr_bank] || bypass);
    assign buf_wr_en = accept;
    assign wr_last   = accept && (buf_wr_addr == AW'(FRAME_LEN - 1));
    assign clr_full  = (state == S_OUT);

    always_comb begin
        full_nxt = full;
        if (clr_full) full_nxt[fft_bank] = 1'b0;
        if (wr_last)  full_nxt[buf_wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_wr_bank <= 1'b0;
            buf_wr_addr <= '0;
            overrun     <= 1'b0;
            full        <= 2'b00;
        end else begin
            full <= full_nxt;
            if (accept) begin
                if (wr_last) begin
                    buf_wr_addr <= '0;
                    buf_wr_bank <= ~buf_wr_bank;
                end else begin
                    buf_wr_addr <= buf_wr_addr + 1'b1;
                end
            end else if (fir_valid && !done) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            fft_stage <= '0;
            fft_bank  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (full[fft_bank]) begin
                        fft_stage <= '0;
                        state     <= S_START;
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (stage_done) begin
                        if (fft_stage == SW'(NUM_STAGES - 1)) begin
                            state <= S_OUT;
                        end else begin
                            fft_stage <= fft_stage + 1'b1;
                            state     <= S_START;
                        end
                    end
                end
                S_OUT: begin
                    fft_bank <= ~fft_bank;
                    if (frame_cnt != 7'(NUM_FRAMES)) frame_cnt <= frame_cnt + 1'b1;
                    if (frame_cnt == 7'(NUM_FRAMES - 1)) state <= S_DONE;
                    else                                 state <= S_IDLE;
                end
                S_DONE:  state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fas_fft_sched.sv
// Bench for fas_fft_sched: a cycle model of buffer fill plus frame timing arithmetic
// predicts write-side outputs each cycle and the bank/cycle/index of every frame.
module tb_fas_fft_sched;

    localparam int FRAME_LEN  = 16;
    localparam int NUM_STAGES = 4;
    localparam int NUM_FRAMES = 64;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam int NEVER = 32'h7fffffff;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fir_valid = 1'b0;
    logic       stage_done = 1'b0;
    logic       buf_wr_en, buf_wr_bank, fft_start, fft_bank, fft_valid, done, overrun;
    logic [3:0] buf_wr_addr;
    logic [1:0] fft_stage;
    logic [6:0] frame_cnt;
    logic [2:0] fsm_state;

    fas_fft_sched #(.FRAME_LEN(FRAME_LEN), .NUM_STAGES(NUM_STAGES), .NUM_FRAMES(NUM_FRAMES)) dut (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .stage_done(stage_done),
        .buf_wr_en(buf_wr_en), .buf_wr_bank(buf_wr_bank), .buf_wr_addr(buf_wr_addr),
        .fft_start(fft_start), .fft_bank(fft_bank), .fft_stage(fft_stage),
        .fft_valid(fft_valid), .frame_cnt(frame_cnt), .done(done), .overrun(overrun),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;
    int n_valid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Expected frame entry: {index[6:0], bank, out cycle[23:0]}
    logic [31:0] exp_q[$];
    int out_q[$];
    int sd_q[$];
    int n_starts;

    int lat_base, stall_frame, stall_lat;
    bit noise_en;

    int m_wb, m_wa, m_last_o, m_sched, m_frames_out, m_accepts, m_bypass;
    bit m_done, m_overrun;
    bit m_full[2];
    int m_clear_at[2];

    function automatic int stage_lat(input int k, input int j);
        return (k == stall_frame && j == 0) ? stall_lat : lat_base;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_wb = 0; m_wa = 0; m_last_o = -100; m_sched = 0; m_frames_out = 0;
        m_accepts = 0; m_bypass = 0; m_done = 0; m_overrun = 0;
        m_full[0] = 0; m_full[1] = 0;
        m_clear_at[0] = NEVER; m_clear_at[1] = NEVER;
        exp_q.delete(); out_q.delete(); sd_q.delete();
        n_starts = 0;
    endtask

    // ---------------- driver ----------------
    task automatic tick(input bit fv);
        int t, o, s;
        bit sd, acc, byp;
        @(negedge clk);
        t = cyc;
        sd = 0;
        if (fft_start) begin
            sd_q.push_back(t + stage_lat(n_starts / NUM_STAGES, n_starts % NUM_STAGES));
            n_starts++;
            if (noise_en) sd = 1;
        end
        if (sd_q.size() > 0 && sd_q[0] == t) begin
            sd = 1;
            void'(sd_q.pop_front());
        end
        if (noise_en && t > m_last_o && $urandom_range(0, 3) == 0) sd = 1;
        fir_valid  = fv;
        stage_done = sd;
        #1;
        byp = m_full[m_wb] && (t == m_clear_at[m_wb]) && (m_wa == 0);
        acc = fv && !m_done && (!m_full[m_wb] || byp);
        chk("buf_wr_en",   32'(buf_wr_en),   32'(acc));
        chk("buf_wr_addr", 32'(buf_wr_addr), m_wa);
        chk("buf_wr_bank", 32'(buf_wr_bank), m_wb);
        chk("overrun",     32'(overrun),     32'(m_overrun));
        chk("done",        32'(done),        32'(m_done));
        chk("frame_cnt",   32'(frame_cnt),   m_frames_out);
        // state advance for the edge that ends cycle t
        if (fv && !m_done && !acc) m_overrun = 1;
        if (acc && byp) m_bypass++;
        for (int b = 0; b < 2; b++)
            if (m_full[b] && t == m_clear_at[b]) m_full[b] = 0;
        if (out_q.size() > 0 && out_q[0] == t) begin
            void'(out_q.pop_front());
            m_frames_out++;
            if (m_frames_out == NUM_FRAMES) m_done = 1;
        end
        if (acc) begin
            m_accepts++;
            if (m_wa == FRAME_LEN - 1) begin
                m_full[m_wb] = 1;
                if (m_sched < NUM_FRAMES) begin
                    s = imax(t + 2, m_last_o + 2);
                    o = s;
                    for (int j = 0; j < NUM_STAGES; j++) o += 1 + stage_lat(m_sched, j);
                    m_last_o = o;
                    m_clear_at[m_wb] = o;
                    out_q.push_back(o);
                    exp_q.push_back({7'(m_sched), 1'(m_wb), 24'(o)});
                end else begin
                    m_clear_at[m_wb] = NEVER;
                end
                m_sched++;
                m_wa = 0;
                m_wb ^= 1;
            end else begin
                m_wa++;
            end
        end
    endtask

    task automatic run(input int n, input int pct);
        for (int i = 0; i < n; i++) tick($urandom_range(0, 99) < pct);
    endtask

    task automatic feed_accepts(input int n, input int pct);
        int target;
        int budget;
        target = m_accepts + n;
        budget = 2000;
        while (m_accepts < target && budget > 0) begin
            tick($urandom_range(0, 99) < pct);
            budget--;
        end
        if (m_accepts < target) fail("feed_accepts_timeout");
    endtask

    task automatic drain();
        int budget;
        budget = 1000;
        while ((cyc <= m_last_o + 1 || exp_q.size() > 0) && budget > 0) begin
            tick(0);
            budget--;
        end
        if (budget == 0) fail("drain_timeout");
        tick(0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_fft_start"},   32'(fft_start),   0);
        chk({tag, "_fft_valid"},   32'(fft_valid),   0);
        chk({tag, "_done"},        32'(done),        0);
        chk({tag, "_overrun"},     32'(overrun),     0);
        chk({tag, "_frame_cnt"},   32'(frame_cnt),   0);
        chk({tag, "_buf_wr_en"},   32'(buf_wr_en),   0);
        chk({tag, "_buf_wr_addr"}, 32'(buf_wr_addr), 0);
        chk({tag, "_buf_wr_bank"}, 32'(buf_wr_bank), 0);
        chk({tag, "_fft_bank"},    32'(fft_bank),    0);
        chk({tag, "_fft_stage"},   32'(fft_stage),   0);
        chk({tag, "_fsm_state"},   32'(fsm_state),   0);
    endtask

    task automatic do_reset(input string tag);
        fir_valid  = 0;
        stage_done = 0;
        rst = 1;
        #1;
        check_zero(tag);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int exp_stage;
        logic [31:0] e;
        exp_stage = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_stage = 0;
            end else begin
                if (fft_start) begin
                    if (exp_q.size() == 0) begin
                        fail("fft_start_unexpected");
                    end else begin
                        e = exp_q[0];
                        chk("fft_start_bank", 32'(fft_bank), 32'(e[24]));
                    end
                    chk("fft_stage", 32'(fft_stage), exp_stage);
                    exp_stage = (exp_stage + 1) % NUM_STAGES;
                end
                if (fft_valid) begin
                    n_valid++;
                    if (exp_q.size() == 0) begin
                        fail("fft_valid_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        chk("fft_valid_bank",  32'(fft_bank),     32'(e[24]));
                        chk("fft_valid_cycle", cyc & 32'hffffff, 32'(e[23:0]));
                        chk("fft_valid_index", 32'(frame_cnt),    32'(e[31:25]));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        bit found;
        lat_base = 2; stall_frame = -1; stall_lat = 0; noise_en = 0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 0;

        // single frame, stage_done two cycles after each start
        n_valid = 0;
        feed_accepts(16, 60);
        drain();
        chk("one_frame_cnt",   32'(frame_cnt), 1);
        chk("one_frame_bank",  32'(fft_bank),  1);
        chk("one_frame_valid", n_valid,        1);

        // reset during WAIT of stage 2, then a fresh frame
        feed_accepts(16, 100);
        found = 0;
        budget = 100;
        while (!found && budget > 0) begin
            tick(0);
            budget--;
            if (fsm_state == ST_WAIT && fft_stage == 2'd2) found = 1;
        end
        if (!found) fail("reach_wait_stage2");
        do_reset("mid_frame_reset");
        lat_base = $urandom_range(1, 3);
        feed_accepts(16, 70);
        drain();
        chk("after_reset_frame_cnt", 32'(frame_cnt), 1);

        // spurious stage_done in IDLE/START, random fill rate
        noise_en = 1;
        lat_base = $urandom_range(1, 3);
        run(300, 55);
        drain();
        noise_en = 0;

        // OUT of bank 0 coincides with the first sample for bank 0
        do_reset("bypass_reset");
        lat_base = 3;
        for (int i = 0; i < 34; i++) tick(i != 20);
        drain();
        chk("bypass_hits",    m_bypass,      1);
        chk("bypass_overrun", 32'(overrun),  0);

        // stalled first frame: bank 1 fills, samples dropped
        do_reset("stall_reset");
        lat_base = 1; stall_frame = 0; stall_lat = 41;
        run(100, 100);
        drain();
        stall_frame = -1;
        chk("stall_overrun", 32'(overrun), 1);

        // continuous stream through all frames and beyond
        do_reset("long_reset");
        lat_base = 1;
        n_valid = 0;
        run(1100, 100);
        drain();
        chk("long_done",      32'(done),      1);
        chk("long_frame_cnt", 32'(frame_cnt), NUM_FRAMES);
        chk("long_overrun",   32'(overrun),   0);
        chk("long_valids",    n_valid,        NUM_FRAMES);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        fail("global_timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
